wb_burst_master: RTL and testbench

//  Synthesizable Wishbone classic initiator. Moves 64-bit words to/from accelerator regions (query 0x3001_0000,

---
 rtl/wb_burst_master.sv | 211 +++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic initiator that moves 64-bit words as two 32-bit beats
// (lower half first) between a command/data stream port and a Wishbone slave.
module wb_burst_master #(
   parameter int unsigned CNT_W   = 9,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [31:0]      cmd_base,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [63:0]      wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [63:0]      rd_data,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   input  logic             wbm_ack_i,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLo,
      StHi,
      StPush,
      StDone
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_we, w_we_nxt;
   logic [31:0]      r_base, w_base_nxt;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic [CNT_W-1:0] r_idx, w_idx_nxt;
   logic [63:0]      r_word, w_word_nxt;
   logic [63:0]      r_rd, w_rd_nxt;
   logic             r_cyc, w_cyc_nxt;
   logic             r_gap, w_gap_nxt;   // idle cycle between the two beats of a word
   logic             r_err, w_err_nxt;
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;   // cycles the current strobe has waited for ack

   logic             w_beat;
   logic             w_hi;
   logic             w_stb;
   logic [CNT_W-1:0] w_idx_inc;
   logic             w_last;

   assign w_beat    = (r_state == StLo) || (r_state == StHi);
   assign w_hi      = (r_state == StHi);
   assign w_stb     = w_beat && !r_gap;
   assign w_idx_inc = r_idx + 1'b1;
   assign w_last    = (w_idx_inc == r_count);

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_we    <= 1'b0;
         r_base  <= '0;
         r_count <= '0;
         r_idx   <= '0;
         r_word  <= '0;
         r_rd    <= '0;
         r_cyc   <= 1'b0;
         r_gap   <= 1'b0;
         r_err   <= 1'b0;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_we_nxt;
         r_base  <= w_base_nxt;
         r_count <= w_count_nxt;
         r_idx   <= w_idx_nxt;
         r_word  <= w_word_nxt;
         r_rd    <= w_rd_nxt;
         r_cyc   <= w_cyc_nxt;
         r_gap   <= w_gap_nxt;
         r_err   <= w_err_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   // Next-state logic: command accept, word fetch, beat handshakes, read push and timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_we_nxt    = r_we;
      w_base_nxt  = r_base;
      w_count_nxt = r_count;
      w_idx_nxt   = r_idx;
      w_word_nxt  = r_word;
      w_rd_nxt    = r_rd;
      w_cyc_nxt   = r_cyc;
      w_gap_nxt   = r_gap;
      w_err_nxt   = r_err;
      w_tmo_nxt   = '0;

      case (r_state)
         StIdle: begin
            if (cmd_valid) begin
               w_we_nxt    = cmd_write;
               w_base_nxt  = cmd_base;
               w_count_nxt = cmd_count;
               w_idx_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_gap_nxt   = 1'b0;
               if (cmd_count == '0) begin
                  w_state_nxt = StDone;
               end else if (cmd_write) begin
                  w_state_nxt = StFetch;
               end else begin
                  w_state_nxt = StLo;
                  w_cyc_nxt   = 1'b1;
               end
            end
         end
         StFetch: begin
            if (wr_valid) begin
               w_word_nxt  = wr_data;
               w_state_nxt = StLo;
               w_cyc_nxt   = 1'b1;
            end
         end
         StLo, StHi: begin
            if (r_gap) begin
               // Strobe is low this cycle; any ack is ignored.
               w_gap_nxt = 1'b0;
            end else if (wbm_ack_i) begin
               if (!r_we) begin
                  if (w_hi) w_rd_nxt[63:32] = wbm_dat_i;
                  else      w_rd_nxt[31:0]  = wbm_dat_i;
               end
               if (!w_hi) begin
                  w_state_nxt = StHi;
                  w_gap_nxt   = 1'b1;
               end else if (!r_we) begin
                  w_state_nxt = StPush;
               end else begin
                  w_idx_nxt = w_idx_inc;
                  if (w_last) begin
                     w_state_nxt = StDone;
                     w_cyc_nxt   = 1'b0;
                  end else begin
                     w_state_nxt = StFetch;
                  end
               end
            end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = StDone;
               w_cyc_nxt   = 1'b0;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         StPush: begin
            if (rd_ready) begin
               w_idx_nxt = w_idx_inc;
               if (w_last) begin
                  w_state_nxt = StDone;
                  w_cyc_nxt   = 1'b0;
               end else begin
                  w_state_nxt = StLo;
               end
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
            w_cyc_nxt   = 1'b0;
         end
         default: begin
            w_state_nxt = StIdle;
            w_cyc_nxt   = 1'b0;
         end
      endcase
   end

   // Outputs decoded from registered state only.
   always_comb begin
      cmd_ready = (r_state == StIdle);
      wr_ready  = (r_state == StFetch);
      rd_valid  = (r_state == StPush);
      rd_data   = r_rd;
      busy      = (r_state != StIdle);
      done      = (r_state == StDone);
      err       = r_err;
      wbm_cyc_o = r_cyc;
      wbm_stb_o = w_stb;
      wbm_we_o  = w_beat && r_we;
      wbm_sel_o = 4'hF;
      wbm_adr_o = '0;
      wbm_dat_o = '0;
      if (w_beat) begin
         wbm_adr_o = r_base + 32'({r_idx, 3'b000}) + {29'd0, w_hi, 2'b00};
         if (r_we) wbm_dat_o = w_hi ? r_word[63:32] : r_word[31:0];
      end
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// Testbench for wb_burst_master: directed table, hand-written corner sequences and
// randomized commands checked against a word/beat level reference model.
module tb_wb_burst_master;

   localparam int unsigned CNT_W   = 9;
   localparam int unsigned TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_write = 1'b0;
   logic [31:0]      cmd_base = '0;
   logic [CNT_W-1:0] cmd_count = '0;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [63:0]      wr_data = '0;
   logic             rd_valid;
   logic             rd_ready = 1'b0;
   logic [63:0]      rd_data;
   logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]       wbm_sel_o;
   logic [31:0]      wbm_adr_o, wbm_dat_o;
   logic [31:0]      wbm_dat_i = '0;
   logic             wbm_ack_i = 1'b0;
   logic             busy, done, err;

   always #5 clk = ~clk;

   wb_burst_master #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_base(cmd_base), .cmd_count(cmd_count),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
      .busy(busy), .done(done), .err(err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- Wishbone slave model and protocol monitor ----------------
   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } beat_t;

   int          slv_lat = 0;
   int          slv_acks_left = -1;
   bit          slv_noise = 1'b0;
   logic [31:0] rq[$];
   logic [31:0] sent [logic [31:0]];
   beat_t       beats[$];
   int          wcnt = 0;
   int          viol = 0;
   bit          real_ack = 1'b0;
   bit          prev_stb = 1'b0;
   logic [31:0] prev_adr = '0, prev_dat = '0;
   logic        prev_we = 1'b0;
   logic [31:0] slv_d;

   always @(posedge clk) begin
      #1;
      if (wbm_stb_o) begin
         if (real_ack) viol++;
         if (!wbm_cyc_o || wbm_sel_o != 4'hF) viol++;
         if (prev_stb && !real_ack &&
             (wbm_adr_o != prev_adr || wbm_dat_o != prev_dat || wbm_we_o != prev_we)) viol++;
         if (wcnt >= slv_lat && slv_acks_left != 0) begin
            slv_d = (rq.size() > 0) ? rq.pop_front() : $urandom;
            wbm_ack_i = 1'b1;
            wbm_dat_i = slv_d;
            if (!wbm_we_o) sent[wbm_adr_o] = slv_d;
            beats.push_back('{we: wbm_we_o, adr: wbm_adr_o, dat: wbm_dat_o});
            real_ack = 1'b1;
            wcnt = 0;
            if (slv_acks_left > 0) slv_acks_left--;
         end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
            real_ack  = 1'b0;
            wcnt++;
         end
      end else begin
         // Stray acks while the strobe is low must be ignored by the master.
         wbm_ack_i = slv_noise && ($urandom_range(0, 3) == 0);
         wbm_dat_i = $urandom;
         real_ack  = 1'b0;
         wcnt      = 0;
      end
      prev_stb = wbm_stb_o;
      prev_adr = wbm_adr_o;
      prev_dat = wbm_dat_o;
      prev_we  = wbm_we_o;
   end

   // ---------------- Command driver ----------------
   logic [63:0] words [0:63];
   logic [63:0] rdq[$];
   int          done_cnt, done_cyc, stb_cnt, rdv_cyc, cyc_drop;
   logic        err_at_done;

   function automatic int pick(input int g);
      return (g < 0) ? int'($urandom_range(0, 3)) : g;
   endfunction

   task automatic run_cmd(input logic we, input logic [31:0] base, input int cnt,
                          input int wgap, input int rgap);
      int n = 0;
      int wi = 0;
      int wg, rg;
      bit fin = 1'b0;
      bit seen_stb = 1'b0;
      beats.delete();
      rdq.delete();
      sent.delete();
      viol = 0;
      done_cnt = 0; done_cyc = -1; stb_cnt = 0; rdv_cyc = 0; cyc_drop = 0; err_at_done = 1'bx;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = we;
      cmd_base  = base;
      cmd_count = CNT_W'(cnt);
      wg = pick(wgap);
      rg = pick(rgap);
      while (!fin && n < 3000) begin
         @(posedge clk); #1;
         n++;
         cmd_valid = 1'b0;
         wr_valid  = 1'b0;
         rd_ready  = 1'b0;
         if (done) begin
            done_cnt++;
            done_cyc    = n;
            err_at_done = err;
            fin = 1'b1;
         end
         if (wbm_stb_o) begin
            stb_cnt++;
            seen_stb = 1'b1;
         end else if (seen_stb && !wbm_cyc_o && !done) begin
            cyc_drop++;
         end
         if (wr_ready && wi < cnt) begin
            if (wg == 0) begin
               wr_valid = 1'b1;
               wr_data  = words[wi];
               wi++;
               wg = pick(wgap);
            end else begin
               wg--;
            end
         end
         if (rd_valid) begin
            rdv_cyc++;
            if (rg == 0) begin
               rd_ready = 1'b1;
               rdq.push_back(rd_data);
               rg = pick(rgap);
            end else begin
               rg--;
            end
         end
      end
      if (!fin) chk("done within budget", 64'(fin), 64'd1);
      @(posedge clk); #1;
      chk("done single pulse", 64'(done), 64'd0);
      chk("idle after done", 64'({cmd_ready, busy}), 64'b10);
   endtask

   // Reference model: beat k of a command targets base + (k/2)*8 + (k%2)*4 and carries
   // the matching half of word k/2; a read word is {upper beat data, lower beat data}.
   task automatic check_model(input string tag, input logic we, input logic [31:0] base,
                              input int cnt);
      logic [31:0] a;
      logic [31:0] d;
      logic [63:0] w;
      chk($sformatf("%s beat count", tag), 64'(beats.size()), 64'(2 * cnt));
      for (int k = 0; k < beats.size() && k < 2 * cnt; k++) begin
         a = base + 32'((k / 2) * 8 + (k % 2) * 4);
         w = words[k / 2];
         d = !we ? 32'h0 : ((k % 2) != 0) ? w[63:32] : w[31:0];
         chk($sformatf("%s beat%0d adr", tag, k), 64'(beats[k].adr), 64'(a));
         chk($sformatf("%s beat%0d we/dat", tag, k), 64'({beats[k].we, beats[k].dat}),
             64'({we, d}));
      end
      if (!we) begin
         chk($sformatf("%s read words", tag), 64'(rdq.size()), 64'(cnt));
         for (int i = 0; i < rdq.size() && i < cnt; i++) begin
            a = base + 32'(i * 8);
            w = 'x;
            if (sent.exists(a) && sent.exists(a + 32'd4)) w = {sent[a + 32'd4], sent[a]};
            chk($sformatf("%s rd word%0d", tag, i), rdq[i], w);
         end
      end
      chk($sformatf("%s done pulses", tag), 64'(done_cnt), 64'd1);
      chk($sformatf("%s protocol", tag), 64'(viol), 64'd0);
      chk($sformatf("%s cyc held", tag), 64'(cyc_drop), 64'd0);
   endtask

   // ---------------- Directed table ----------------
   typedef struct {
      logic        we;
      logic [31:0] base;
      int          cnt;
      int          lat;
      int          wgap;
      int          rgap;
      logic [63:0] w0;        // word i = w0 + i * 0x0101_0101_0101_0101
      logic [31:0] rq0, rq1;  // slave data for the first two read beats
      int          exp_beats;
      logic [31:0] exp_adr0, exp_adrn;
      logic [31:0] exp_dat0, exp_datn;
      logic [63:0] exp_rd0;
      int          exp_done_cyc;  // -1: not checked
      int          exp_rdv;
   } vec_t;

   vec_t vt [6];

   initial begin
      bit          found;
      int          n;
      logic [31:0] rbase;
      int          rcnt;
      logic        rwe;

      vt[0] = '{1'b1, 32'h3001_0010, 1, 1, 0, 0, 64'h000b_cdef_0123_4567, 32'h0, 32'h0,
                2, 32'h3001_0010, 32'h3001_0014, 32'h0123_4567, 32'h000b_cdef, 64'h0, 7, 0};
      vt[1] = '{1'b0, 32'h3003_0038, 1, 0, 0, 2, 64'h0, 32'hDEAD_BEEF, 32'h1100_1010,
                2, 32'h3003_0038, 32'h3003_003C, 32'h0, 32'h0, 64'h1100_1010_DEAD_BEEF, 7, 3};
      vt[2] = '{1'b1, 32'h3001_0000, 3, 0, 2, 0, 64'h1000_0000_2000_0000, 32'h0, 32'h0,
                6, 32'h3001_0000, 32'h3001_0014, 32'h2000_0000, 32'h1202_0202, 64'h0, -1, 0};
      vt[3] = '{1'b1, 32'h3002_0000, 0, 0, 0, 0, 64'h0, 32'h0, 32'h0,
                0, 32'h0, 32'h0, 32'h0, 32'h0, 64'h0, 1, 0};
      vt[4] = '{1'b0, 32'hFFFF_FFF8, 2, 1, 0, 1, 64'h0, 32'h0000_0001, 32'h8000_0000,
                4, 32'hFFFF_FFF8, 32'h0000_0004, 32'h0, 32'h0, 64'h8000_0000_0000_0001, -1, 4};
      vt[5] = '{1'b1, 32'h3002_0100, 4, 3, 1, 0, 64'hA5A5_0000_5A5A_0000, 32'h0, 32'h0,
                8, 32'h3002_0100, 32'h3002_011C, 32'h5A5A_0000, 32'hA8A8_0303, 64'h0, -1, 0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
      chk("reset outputs", 64'({busy, done, err, wr_ready, rd_valid, wbm_cyc_o, wbm_stb_o,
                                wbm_we_o}), 64'd0);
      chk("reset adr/dat", {wbm_adr_o, wbm_dat_o}, 64'd0);
      chk("reset rd_data", rd_data, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         slv_lat = vt[i].lat;
         for (int j = 0; j < 64; j++) words[j] = vt[i].w0 + 64'(j) * 64'h0101_0101_0101_0101;
         rq.delete();
         if (!vt[i].we) begin
            rq.push_back(vt[i].rq0);
            rq.push_back(vt[i].rq1);
         end
         run_cmd(vt[i].we, vt[i].base, vt[i].cnt, vt[i].wgap, vt[i].rgap);
         check_model($sformatf("vec%0d", i), vt[i].we, vt[i].base, vt[i].cnt);
         chk($sformatf("vec%0d nbeats", i), 64'(beats.size()), 64'(vt[i].exp_beats));
         chk($sformatf("vec%0d err", i), 64'(err_at_done), 64'd0);
         if (beats.size() > 0) begin
            chk($sformatf("vec%0d adr0", i), 64'(beats[0].adr), 64'(vt[i].exp_adr0));
            chk($sformatf("vec%0d adrn", i), 64'(beats[$].adr), 64'(vt[i].exp_adrn));
            chk($sformatf("vec%0d dat0", i), 64'(beats[0].dat), 64'(vt[i].exp_dat0));
            chk($sformatf("vec%0d datn", i), 64'(beats[$].dat), 64'(vt[i].exp_datn));
         end
         if (vt[i].exp_done_cyc >= 0)
            chk($sformatf("vec%0d done cycle", i), 64'(done_cyc), 64'(vt[i].exp_done_cyc));
         if (vt[i].cnt == 0) chk($sformatf("vec%0d no stb", i), 64'(stb_cnt), 64'd0);
         if (!vt[i].we) begin
            chk($sformatf("vec%0d rd_valid cycles", i), 64'(rdv_cyc), 64'(vt[i].exp_rdv));
            if (rdq.size() > 0) chk($sformatf("vec%0d rd0", i), rdq[0], vt[i].exp_rd0);
         end
      end

      // Timeout: slave never acks.
      slv_lat = 1_000_000;
      rq.delete();
      run_cmd(1'b1, 32'h3001_0000, 2, 0, 0);
      chk("timeout stb cycles", 64'(stb_cnt), 64'(TIMEOUT));
      chk("timeout beats", 64'(beats.size()), 64'd0);
      chk("timeout err", 64'(err_at_done), 64'd1);
      chk("timeout done", 64'(done_cnt), 64'd1);
      @(posedge clk); #1;
      chk("err sticky", 64'({err, wbm_cyc_o, wbm_stb_o}), 64'b100);
      slv_lat = 0;
      run_cmd(1'b1, 32'h3001_0000, 0, 0, 0);
      chk("err cleared on accept", 64'(err_at_done), 64'd0);

      // Reset asserted during the upper beat of a read.
      slv_lat = 0;
      slv_acks_left = 1;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_base  = 32'h3003_0000;
      cmd_count = CNT_W'(1);
      found = 1'b0;
      n = 0;
      while (!found && n < 50) begin
         @(posedge clk); #1;
         n++;
         cmd_valid = 1'b0;
         if (wbm_stb_o && wbm_adr_o == 32'h3003_0004) found = 1'b1;
      end
      chk("reached upper beat", 64'(found), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid-beat reset bus", 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
      chk("mid-beat reset ctrl", 64'({cmd_ready, rd_valid, busy, done}), 64'b1000);
      rst_n = 1'b1;
      slv_acks_left = -1;

      // Randomized commands against the reference model, with stray acks while stb is low.
      slv_noise = 1'b1;
      for (int t = 0; t < 40; t++) begin
         rwe  = 1'($urandom_range(0, 1));
         rcnt = int'($urandom_range(0, 6));
         case ($urandom_range(0, 3))
            0:       rbase = 32'h3001_0000 + ($urandom & 32'h0000_0FF8);
            1:       rbase = 32'h3002_0000 + ($urandom & 32'h0000_0FFC);
            2:       rbase = 32'hFFFF_FFE0 + ($urandom & 32'h0000_0018);
            default: rbase = $urandom;
         endcase
         slv_lat = int'($urandom_range(0, 3));
         for (int j = 0; j < 64; j++) words[j] = {$urandom, $urandom};
         run_cmd(rwe, rbase, rcnt, -1, -1);
         check_model($sformatf("rnd%0d", t), rwe, rbase, rcnt);
         chk($sformatf("rnd%0d err", t), 64'(err_at_done), 64'd0);
      end
      slv_noise = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
